async_uart_transceiver: RTL and testbench
=========================================

Name: async_uart_transceiver

Overview:
8N1 UART transceiver combining an asynchronous serial receiver and transmitter that share one clock and reset. It sits between the board's rx/tx pins and the io controller. The receiver issues a one-cycle byte strobe; the transmitter accepts a byte through a start/busy handshake.

Parameters:
CLK_FREQ, 100000000, clock frequency in Hz.
BAUD, 115200, line rate in bit/s; BIT_CYCLES = CLK_FREQ/BAUD (integer division; 868 at defaults).
IDLE_BITS, 16, number of bit periods of continuous mark after a stop bit before the line counts as idle.

Ports:
clk_100  in  1  system clock; all logic on the rising edge.
rst_n  in  1  reset; asynchronous assert, active-low.
rxd  in  1  serial input, asynchronous to the clock.
rxd_data_ready  out  1  one-cycle strobe: a valid byte is on rxd_data.
rxd_data  out  8  last received byte; held until the next valid byte.
rxd_idle  out  1  high while the receive line has been idle for IDLE_BITS or more.
txd_start  in  1  request to send txd_data; honoured only when txd_busy=0.
txd_data  in  8  byte to transmit; sampled in the accept cycle.
txd  out  1  serial output; idles high.
txd_busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values (rst_n=0, asynchronous): txd=1, txd_busy=0, rxd_data_ready=0, rxd_data=0x00, rxd_idle=1. All counters and FSMs return to IDLE. A frame in progress on either side is aborted with no strobe, and the frame is not resumed.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly BIT_CYCLES clocks.
- TX FSM states: IDLE -> START -> DATA0..DATA7 -> STOP -> IDLE.
  - Accept: in the cycle where txd_start=1 and txd_busy=0, latch txd_data.
  - On the next cycle, txd_busy=1 and txd=0.
  - txd_busy stays high for exactly 10*BIT_CYCLES clocks, then falls.
  - txd_start while busy is ignored and not queued.
  - If txd_start is held high, the next frame is accepted in the first cycle txd_busy=0, giving back-to-back frames with no extra idle bit.
  - txd_data may change after the accept cycle without corrupting the frame.
- RX path:
  - rxd passes through a 2-flop synchronizer (initialised to 1).
  - RX FSM states: IDLE -> START_CHK -> DATA -> STOP -> IDLE.
  - IDLE: a synchronized falling edge starts a half-bit counter.
  - START_CHK: at BIT_CYCLES/2 the line is sampled. If it is high, treat it as a glitch and return to IDLE with no output. If low, take 8 data samples, then the stop sample, each BIT_CYCLES apart (mid-bit).
  - STOP: stop sample =1 updates rxd_data and pulses rxd_data_ready for exactly one cycle at the stop-sample cycle. Stop sample =0 is a framing error: byte discarded, no strobe, rxd_data unchanged.
  - Either way the FSM returns to IDLE and re-arms on the next falling edge; no wait for a full stop period.
  - Strobe latency from the start-bit falling edge on rxd: 9.5*BIT_CYCLES + 2 (synchronizer) clocks, ±1.
- rxd_idle:
  - Drops to 0 on the start-bit detection.
  - Rises after IDLE_BITS*BIT_CYCLES consecutive clocks of synchronized rxd=1 with the FSM in IDLE.
- RX and TX are fully independent: simultaneous activity, including loopback txd->rxd, must work.

Optional Feature:
Macro RXD_ENDOFPACKET_EN.
- Defined: extra output port rxd_endofpacket (out, 1). It pulses high for one cycle when rxd_idle rises, but only if at least one byte was strobed since the previous pulse. Its reset value is 0.
- Undefined: the port does not exist and no related logic is built; all other behaviour is identical.

Test Plan:
- Reset mid-TX: start a frame, pulse rst_n low at bit 3 -> txd=1 and txd_busy=0 immediately; no further activity until a new start.
- TX single byte 0xA5: pulse txd_start one cycle -> txd_busy high for 8680 clocks. txd bit sequence 0,1,0,1,0,0,1,0,1,1, each 868 clocks.
- TX back-to-back: hold txd_start=1 with data 0x55 then 0x0F -> second start bit begins the cycle after busy falls; a third request during busy is ignored.
- RX byte 0x3C driven at 115200 -> one rxd_data_ready pulse, rxd_data=0x3C; rxd_idle falls at the start bit and rises 16 bit times after the stop bit.
- RX faults:
  - A 300 ns low glitch -> no strobe.
  - A frame with stop bit 0 -> no strobe, rxd_data keeps its previous value.
  - A valid frame afterwards -> received correctly.
- Loopback txd->rxd with bytes 0x00, 0xFF, 0x81 sent back-to-back -> three strobes with matching data. With RXD_ENDOFPACKET_EN, exactly one rxd_endofpacket pulse after the last byte.

Source files
------------

// File: rtl/async_uart_transceiver.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// async_uart_transceiver
//
// 8N1 UART receiver and transmitter sharing one clock and reset. The two halves
// are fully independent, so simultaneous traffic and txd->rxd loopback work.
//
// Parameters:
//   CLK_FREQ   clock frequency in Hz
//   BAUD       line rate in bit/s; one bit lasts CLK_FREQ/BAUD clocks
//   IDLE_BITS  bit periods of continuous mark before the receive line is idle
//
// Ports:
//   clk_100          in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   rxd              in   serial input (asynchronous to clk_100)
//   rxd_data_ready   out  one-cycle strobe, rxd_data holds a new byte
//   rxd_data[7:0]    out  last correctly framed byte
//   rxd_idle         out  receive line idle for IDLE_BITS bit periods or more
//   rxd_endofpacket  out  (only with RXD_ENDOFPACKET_EN) one-cycle pulse when
//                         rxd_idle rises after at least one received byte
//   txd_start        in   send request, honoured while txd_busy is low
//   txd_data[7:0]    in   byte to send, sampled in the accept cycle
//   txd              out  serial output, idles high
//   txd_busy         out  high while a frame is being sent
//
// Optional feature macro: RXD_ENDOFPACKET_EN adds the rxd_endofpacket output.
// -----------------------------------------------------------------------------
module async_uart_transceiver #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int IDLE_BITS = 16
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rxd_data_ready,
  output logic [7:0] rxd_data,
  output logic       rxd_idle,
`ifdef RXD_ENDOFPACKET_EN
  output logic       rxd_endofpacket,
`endif
  input  logic       txd_start,
  input  logic [7:0] txd_data,
  output logic       txd,
  output logic       txd_busy
);

  localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int IDLE_CYCLES = IDLE_BITS * BIT_CYCLES;
  localparam int CNT_W       = $clog2(BIT_CYCLES + 1);
  localparam int IDLE_W      = $clog2(IDLE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);

  // ===========================================================================
  // Transmitter
  // ===========================================================================
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  tx_state_e        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             txd_q;
  logic             txd_busy_q;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
      txd_busy_q <= 1'b0;
    end else begin
      // The bit-period counter runs in every non-idle state and wraps at the
      // end of each bit, so all states share one timebase.
      if (tx_state_q != TX_IDLE) begin
        tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + 1'b1;
      end

      case (tx_state_q)
        TX_IDLE: begin
          // Busy is low only here, so this is the accept cycle.
          if (txd_start) begin
            tx_shift_q <= txd_data;
            tx_cnt_q   <= '0;
            txd_q      <= 1'b0;
            txd_busy_q <= 1'b1;
            tx_state_q <= TX_START;
          end
        end

        TX_START: begin
          if (tx_bit_end) begin
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b1, tx_shift_q[7:1]};
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end
        end

        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end
        end

        TX_STOP: begin
          // Busy falls after the full stop bit; a held txd_start is accepted
          // in the very next cycle, giving back-to-back frames.
          if (tx_bit_end) begin
            txd_busy_q <= 1'b0;
            tx_state_q <= TX_IDLE;
          end
        end

        default: begin
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign txd_busy = txd_busy_q;

  // ===========================================================================
  // Receiver
  // ===========================================================================

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  // All start high so reset release never looks like a start bit.
  logic rxd_meta_q;
  logic rxd_sync_q;
  logic rxd_prev_q;
  logic rx_fall;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign rx_fall = rxd_prev_q & ~rxd_sync_q;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START_CHK,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rxd_data_q;
  logic             rxd_ready_q;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rxd_data_q  <= '0;
      rxd_ready_q <= 1'b0;
    end else begin
      rxd_ready_q <= 1'b0;

      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START_CHK;
          end
        end

        RX_START_CHK: begin
          // Mid start bit: a line already back high was only a glitch.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            if (!rxd_sync_q) begin
              rx_bit_q   <= '0;
              rx_state_q <= RX_DATA;
            end else begin
              rx_state_q <= RX_IDLE;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end

        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};  // LSB arrives first
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end

        RX_STOP: begin
          // Return to idle at mid-stop so the next start edge is not missed;
          // a low stop sample drops the byte silently.
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rxd_sync_q) begin
              rxd_data_q  <= rx_shift_q;
              rxd_ready_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end

        default: begin
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign rxd_data_ready = rxd_ready_q;
  assign rxd_data       = rxd_data_q;

  // ---------------------------------------------------------------------------
  // Idle detection: count consecutive mark cycles while the receiver is idle.
  // The counter saturates so a long idle line does not wrap.
  // ---------------------------------------------------------------------------
  logic [IDLE_W-1:0] idle_cnt_q;
  logic              rxd_idle_q;
  logic              idle_counting;
  logic              idle_reached;
  logic              idle_rise;

  assign idle_counting = (rx_state_q == RX_IDLE) && rxd_sync_q;
  assign idle_reached  = idle_counting && (idle_cnt_q == IDLE_LAST);
  assign idle_rise     = idle_reached && !rxd_idle_q;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
      rxd_idle_q <= 1'b1;
    end else begin
      if (idle_counting) begin
        if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end else begin
        idle_cnt_q <= '0;
      end

      if ((rx_state_q == RX_IDLE) && rx_fall) begin
        rxd_idle_q <= 1'b0;
      end else if (idle_reached) begin
        rxd_idle_q <= 1'b1;
      end
    end
  end

  assign rxd_idle = rxd_idle_q;

`ifdef RXD_ENDOFPACKET_EN
  // ---------------------------------------------------------------------------
  // End of packet: remember that a byte arrived, report it once when the line
  // next goes idle.
  // ---------------------------------------------------------------------------
  logic eop_pending_q;
  logic eop_q;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      eop_pending_q <= 1'b0;
      eop_q         <= 1'b0;
    end else begin
      eop_q         <= idle_rise && eop_pending_q;
      eop_pending_q <= (eop_pending_q && !idle_rise) || rxd_ready_q;
    end
  end

  assign rxd_endofpacket = eop_q;
`endif

endmodule

// File: tb/tb_async_uart_transceiver.sv
`timescale 1ns/1ps
module tb_async_uart_transceiver;

  // 64 clocks per bit keeps the run short while a 300 ns glitch (30 clocks)
  // still ends before the half-bit start check.
  localparam int CLK_FREQ  = 100000000;
  localparam int BAUD      = 1562500;
  localparam int IDLE_BITS = 16;
  localparam int BC        = CLK_FREQ / BAUD;
  localparam int LIMIT     = IDLE_BITS * BC;
  localparam int LAT       = (19 * BC) / 2 + 2;

  logic       clk_100 = 1'b0;
  logic       rst_n;
  logic       rxd_drv;
  logic       loop_en;
  logic       rxd;
  logic       rxd_data_ready;
  logic [7:0] rxd_data;
  logic       rxd_idle;
  logic       txd_start;
  logic [7:0] txd_data;
  logic       txd;
  logic       txd_busy;
`ifdef RXD_ENDOFPACKET_EN
  logic       rxd_endofpacket;
`endif

  always #5 clk_100 = ~clk_100;

  assign rxd = loop_en ? txd : rxd_drv;

  async_uart_transceiver #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clk_100        (clk_100),
    .rst_n          (rst_n),
    .rxd            (rxd),
    .rxd_data_ready (rxd_data_ready),
    .rxd_data       (rxd_data),
    .rxd_idle       (rxd_idle),
`ifdef RXD_ENDOFPACKET_EN
    .rxd_endofpacket(rxd_endofpacket),
`endif
    .txd_start      (txd_start),
    .txd_data       (txd_data),
    .txd            (txd),
    .txd_busy       (txd_busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  // Receive monitor
  int         strobe_cnt = 0;
  int         eop_cnt    = 0;
  logic [7:0] strobe_log[$];

  always @(negedge clk_100) begin
    if (rxd_data_ready === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      strobe_log.push_back(rxd_data);
    end
`ifdef RXD_ENDOFPACKET_EN
    if (rxd_endofpacket === 1'b1) eop_cnt <= eop_cnt + 1;
`endif
  end

  // Accept one byte; returns at the first negedge of the frame (start bit).
  task automatic tx_accept(input logic [7:0] d);
    @(negedge clk_100);
    txd_start = 1'b1;
    txd_data  = d;
    @(negedge clk_100);
    txd_start = 1'b0;
    txd_data  = ~d;  // frame must not follow later changes
  endtask

  // Checks all 10*BC cycles of a frame (frame[i] = i-th bit on the line,
  // busy high throughout) and that busy is low right after.
  task automatic check_frame(input string name, input logic [9:0] frame);
    int bad;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int k = 0; k < BC; k++) begin
        if (txd !== frame[b] || txd_busy !== 1'b1) bad++;
        @(negedge clk_100);
      end
      chk($sformatf("%s bit%0d bad cycles", name, b), bad, 0);
    end
    chk($sformatf("%s busy after 10 bits", name), txd_busy, 1'b0);
    chk($sformatf("%s txd after frame", name), txd, 1'b1);
  endtask

  task automatic rx_bit(input logic v);
    rxd_drv = v;
    repeat (BC) @(negedge clk_100);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    rx_bit(stop);
    rxd_drv = 1'b1;
    repeat (2 * BC) @(negedge clk_100);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_strobes;
    logic [7:0] exp_data;
  } rx_vec_t;

  tx_vec_t tx_vecs[4];
  rx_vec_t rx_vecs[6];

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         s0;
    int         e0;
    int         bad;
    int         lat;
    int         idle_wait;
    int         w;
    logic [7:0] lb[3];
    logic [7:0] got;

    // Frames written out by hand: bit i of .frame is the i-th bit on the line.
    tx_vecs[0] = '{8'hA5, 10'b1101001010};
    tx_vecs[1] = '{8'h3C, 10'b1001111000};
    tx_vecs[2] = '{8'h00, 10'b1000000000};
    tx_vecs[3] = '{8'hFF, 10'b1111111110};

    rx_vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5};
    rx_vecs[1] = '{8'h96, 1'b0, 0, 8'hA5};  // framing error keeps old byte
    rx_vecs[2] = '{8'h5A, 1'b1, 1, 8'h5A};
    rx_vecs[3] = '{8'hFF, 1'b1, 1, 8'hFF};
    rx_vecs[4] = '{8'h00, 1'b0, 0, 8'hFF};  // break: all low
    rx_vecs[5] = '{8'h81, 1'b1, 1, 8'h81};

    rst_n     = 1'b0;
    rxd_drv   = 1'b1;
    loop_en   = 1'b0;
    txd_start = 1'b0;
    txd_data  = 8'h00;

    // ---------------- reset values ----------------
    #7;
    chk("reset txd", txd, 1'b1);
    chk("reset txd_busy", txd_busy, 1'b0);
    chk("reset rxd_data_ready", rxd_data_ready, 1'b0);
    chk("reset rxd_data", rxd_data, 8'h00);
    chk("reset rxd_idle", rxd_idle, 1'b1);
`ifdef RXD_ENDOFPACKET_EN
    chk("reset rxd_endofpacket", rxd_endofpacket, 1'b0);
`endif
    repeat (3) @(negedge clk_100);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100);

    // ---------------- TX table ----------------
    for (int v = 0; v < 4; v++) begin
      tx_accept(tx_vecs[v].data);
      check_frame($sformatf("tx 0x%02h", tx_vecs[v].data), tx_vecs[v].frame);
    end

    // ---------------- reset mid-TX ----------------
    tx_accept(8'hA5);
    repeat (3 * BC + BC / 2) @(negedge clk_100);
    chk("midtx busy before reset", txd_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midtx reset txd", txd, 1'b1);
    chk("midtx reset busy", txd_busy, 1'b0);
    @(negedge clk_100);
    rst_n = 1'b1;
    bad = 0;
    repeat (2 * BC) begin
      if (txd !== 1'b1 || txd_busy !== 1'b0) bad++;
      @(negedge clk_100);
    end
    chk("midtx no activity after reset", bad, 0);

    // ---------------- TX back-to-back ----------------
    @(negedge clk_100);
    txd_start = 1'b1;
    txd_data  = 8'h55;
    @(negedge clk_100);
    txd_data  = 8'h0F;  // start held: requests during busy are ignored
    check_frame("b2b 0x55", 10'b1010101010);
    @(negedge clk_100);
    txd_start = 1'b0;
    txd_data  = 8'h00;
    fork
      check_frame("b2b 0x0F", 10'b1000011110);
      begin
        repeat (3 * BC) @(negedge clk_100);
        txd_start = 1'b1;
        txd_data  = 8'hC3;
        @(negedge clk_100);
        txd_start = 1'b0;
      end
    join
    bad = 0;
    repeat (2 * BC) begin
      if (txd !== 1'b1 || txd_busy !== 1'b0) bad++;
      @(negedge clk_100);
    end
    chk("b2b request during busy not queued", bad, 0);

    // ---------------- RX 0x3C with latency and idle timing ----------------
    repeat (LIMIT + BC) @(negedge clk_100);
    chk("rx idle before frame", rxd_idle, 1'b1);
    s0  = strobe_cnt;
    lat = 0;
    idle_wait = 0;
    fork
      rx_send(8'h3C, 1'b1);
      begin
        while (rxd_data_ready !== 1'b1 && lat < 12 * BC) begin
          @(negedge clk_100);
          lat++;
        end
        while (rxd_idle !== 1'b1 && idle_wait < LIMIT + 4 * BC) begin
          @(negedge clk_100);
          idle_wait++;
        end
      end
      begin
        repeat (BC / 2) @(negedge clk_100);
        chk("rx idle low during start bit", rxd_idle, 1'b0);
      end
    join
    chk_range("rx 0x3C strobe latency", lat, LAT, LAT + 2);
    chk("rx 0x3C strobe count", strobe_cnt - s0, 1);
    chk("rx 0x3C data", rxd_data, 8'h3C);
    chk_range("rx idle rise after strobe", idle_wait, LIMIT - 1, LIMIT + 1);

    // ---------------- RX glitch ----------------
    s0 = strobe_cnt;
    rxd_drv = 1'b0;
    #300;
    rxd_drv = 1'b1;
    repeat (2 * BC) @(negedge clk_100);
    chk("rx glitch no strobe", strobe_cnt - s0, 0);
    chk("rx glitch data kept", rxd_data, 8'h3C);

    // ---------------- RX table ----------------
    for (int v = 0; v < 6; v++) begin
      s0 = strobe_cnt;
      rx_send(rx_vecs[v].data, rx_vecs[v].stop);
      chk($sformatf("rx 0x%02h stop=%0d strobes", rx_vecs[v].data, rx_vecs[v].stop),
          strobe_cnt - s0, rx_vecs[v].exp_strobes);
      chk($sformatf("rx 0x%02h stop=%0d data", rx_vecs[v].data, rx_vecs[v].stop),
          rxd_data, rx_vecs[v].exp_data);
    end

    // ---------------- loopback ----------------
    w = 0;
    while (rxd_idle !== 1'b1 && w < LIMIT + 4 * BC) begin
      @(negedge clk_100);
      w++;
    end
    lb[0] = 8'h00;
    lb[1] = 8'hFF;
    lb[2] = 8'h81;
    loop_en = 1'b1;
    strobe_log.delete();
    s0 = strobe_cnt;
    e0 = eop_cnt;
    @(negedge clk_100);
    txd_start = 1'b1;
    txd_data  = lb[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_100);
      if (i < 2) txd_data = lb[i + 1];
      else       txd_start = 1'b0;
      w = 0;
      while (txd_busy === 1'b1 && w < 11 * BC) begin
        @(negedge clk_100);
        w++;
      end
      chk($sformatf("loopback frame %0d busy timeout", i), (w >= 11 * BC), 1'b0);
    end
    w = 0;
    while (rxd_idle !== 1'b1 && w < LIMIT + 4 * BC) begin
      @(negedge clk_100);
      w++;
    end
    chk("loopback idle timeout", (w >= LIMIT + 4 * BC), 1'b0);
    repeat (4) @(negedge clk_100);
    chk("loopback strobe count", strobe_cnt - s0, 3);
    for (int i = 0; i < 3; i++) begin
      got = (strobe_log.size() > i) ? strobe_log[i] : 8'hxx;
      chk($sformatf("loopback byte %0d", i), got, lb[i]);
    end
`ifdef RXD_ENDOFPACKET_EN
    chk("loopback endofpacket pulses", eop_cnt - e0, 1);
`endif
    loop_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
